inter_switch_sched: RTL and testbench

Command-driven scheduler that sequences the inter_switch routing datapath. It queues route commands (source, destination, flex-shift config, beat count, weight flag) and drives the switch's 19-bit ctrl word and weight_switch for exactly the commanded number of accepted beats. After each transfer it holds an idle gap so the switch's output register slice drains before the next route is applied. It sits between the layer-level control sequencer and inter_switch.

---
 rtl/inter_switch_sched.sv | 133 +++++++++++++
 tb/tb_inter_switch_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inter_switch_sched.sv
// Route-command scheduler for inter_switch: queues route commands, drives ctrl/weight_switch
// for the commanded number of accepted beats, then idles so the switch output slice drains.
module inter_switch_sched #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [18:0] IDLE_CTRL    = 19'h10080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] cmd_tdata,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  output logic [18:0] ctrl,
  output logic        weight_switch,
  input  logic        count_switch_tvalid,
  output logic        busy,
  output logic        cmd_done,
  output logic        err_illegal,
  output logic        err_spurious,
  output logic [15:0] beats_left
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef struct packed {
    logic        weight;
    logic [15:0] beats;
    logic [8:0]  shift_reg;
    logic [2:0]  shift_ctrl;
    logic [3:0]  dst;
    logic [2:0]  src;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, legal;
  logic [DW-1:0] drain_cnt, drain_d;
  logic [18:0]   ctrl_d;
  logic [15:0]   beats_d;
  logic          weight_d, done_d, ill_d, spur_d;

  // Extra pointer bit distinguishes full from empty.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign cmd_tready = ~full & ~rst;
  assign push       = cmd_tvalid & cmd_tready;
  assign busy       = (state_q != IDLE) | ~empty;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign legal      = (head.src != 3'd0) && (head.src != 3'd7) &&
                      (head.dst <= 4'd8) && (head.beats != 16'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_t'(cmd_tdata);
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl;
    weight_d = weight_switch;
    beats_d  = beats_left;
    drain_d  = drain_cnt;
    pop      = 1'b0;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    spur_d   = count_switch_tvalid && (state_q != RUN);
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (legal) begin
            ctrl_d   = head[18:0];
            weight_d = head.weight;
            beats_d  = head.beats;
            state_d  = RUN;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Route is withdrawn on the same edge as the final beat so no extra beat slips in.
        if (count_switch_tvalid && beats_left != 16'd0) begin
          beats_d = beats_left - 16'd1;
          if (beats_left == 16'd1) begin
            ctrl_d  = IDLE_CTRL;
            drain_d = DW'(DRAIN_CYCLES);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ctrl          <= IDLE_CTRL;
      weight_switch <= 1'b0;
      beats_left    <= '0;
      drain_cnt     <= '0;
      cmd_done      <= 1'b0;
      err_illegal   <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      ctrl          <= ctrl_d;
      weight_switch <= weight_d;
      beats_left    <= beats_d;
      drain_cnt     <= drain_d;
      cmd_done      <= done_d;
      err_illegal   <= ill_d;
      err_spurious  <= spur_d;
    end
  end

endmodule

// File: tb/tb_inter_switch_sched.sv
// Bench for inter_switch_sched: directed scenarios plus a randomized run against a
// transaction-level model (legal-command queue, beat counts, gap and completion timing).
module tb_inter_switch_sched;

  localparam logic [18:0] IDLE = 19'h10080;
  localparam int          DR   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] cmd_tdata = '0;
  logic        cmd_tvalid = 1'b0;
  logic        cmd_tready;
  logic [18:0] ctrl;
  logic        weight_switch;
  logic        count_switch_tvalid = 1'b0;
  logic        busy, cmd_done, err_illegal, err_spurious;
  logic [15:0] beats_left;

  int total = 0;
  int bad   = 0;

  inter_switch_sched #(.FIFO_DEPTH(4), .DRAIN_CYCLES(DR), .IDLE_CTRL(IDLE)) dut (
    .clk(clk), .rst(rst), .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready), .ctrl(ctrl), .weight_switch(weight_switch),
    .count_switch_tvalid(count_switch_tvalid), .busy(busy), .cmd_done(cmd_done),
    .err_illegal(err_illegal), .err_spurious(err_spurious), .beats_left(beats_left)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input int src, input int dst, input int sc,
                                     input int sr, input int beats, input bit w);
    return {w, 16'(beats), 9'(sr), 3'(sc), 4'(dst), 3'(src)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_tvalid = 1'b0; count_switch_tvalid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_tvalid = 1'b1; cmd_tdata = mk(1, 0, 0, 0, 1, 1'b0); count_switch_tvalid = 1'b0;
    #1;
    total++; if (cmd_tready !== 1'b0) begin bad++; $display("FAIL reset_tready_during: got %b want 0", cmd_tready); end
    tick();
    rst = 1'b0; cmd_tvalid = 1'b0;
    #1;
    total++; if (ctrl !== IDLE) begin bad++; $display("FAIL reset_ctrl: got %h want %h", ctrl, IDLE); end
    total++; if (weight_switch !== 1'b0) begin bad++; $display("FAIL reset_weight: got %b want 0", weight_switch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (beats_left !== 16'd0) begin bad++; $display("FAIL reset_beats: got %0d want 0", beats_left); end
    total++; if ({cmd_done, err_illegal, err_spurious} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {cmd_done, err_illegal, err_spurious}); end
    total++; if (cmd_tready !== 1'b1) begin bad++; $display("FAIL reset_tready_after: got %b want 1", cmd_tready); end
    tick();
    total++; if (ctrl !== IDLE || busy !== 1'b0) begin bad++; $display("FAIL reset_push_dropped: ctrl %h busy %b want %h 0", ctrl, busy, IDLE); end
  endtask

  task automatic test_single();
    logic [35:0] c;
    do_reset();
    c = mk(1, 0, 0, 0, 3, 1'b1);
    cmd_tvalid = 1'b1; cmd_tdata = c; tick(); cmd_tvalid = 1'b0;
    tick();
    total++; if (ctrl !== c[18:0]) begin bad++; $display("FAIL single_ctrl_load: got %h want %h", ctrl, c[18:0]); end
    total++; if (weight_switch !== 1'b1) begin bad++; $display("FAIL single_weight: got %b want 1", weight_switch); end
    total++; if (beats_left !== 16'd3) begin bad++; $display("FAIL single_beats_load: got %0d want 3", beats_left); end
    count_switch_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (beats_left !== 16'(2 - i)) begin bad++; $display("FAIL single_beats_step%0d: got %0d want %0d", i, beats_left, 2 - i); end
      total++; if (ctrl !== ((i < 2) ? c[18:0] : IDLE)) begin bad++; $display("FAIL single_ctrl_step%0d: got %h", i, ctrl); end
    end
    count_switch_tvalid = 1'b0;
    total++; if (weight_switch !== 1'b1) begin bad++; $display("FAIL single_weight_hold: got %b want 1", weight_switch); end
    for (int j = 1; j <= 3; j++) begin
      tick();
      total++; if (cmd_done !== (j == DR)) begin bad++; $display("FAIL single_done_t%0d: got %b want %b", j, cmd_done, j == DR); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] a;
    logic [35:0] cmds [4];
    logic [18:0] exp_q [$];
    int bts [4] = '{1, 2, 1, 2};
    int dones = 0;
    do_reset();
    a = mk(1, 0, 0, 0, 3, 1'b0);
    cmd_tvalid = 1'b1; cmd_tdata = a; tick(); cmd_tvalid = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      cmds[k] = mk(2 + k, k, $urandom_range(0, 7), $urandom_range(0, 511), bts[k], k[0]);
      cmd_tvalid = 1'b1; cmd_tdata = cmds[k]; tick();
    end
    cmd_tvalid = 1'b0;
    total++; if (cmd_tready !== 1'b0) begin bad++; $display("FAIL b2b_tready_full: got %b want 0", cmd_tready); end
    // Each route is visible for its beat count, followed by DR+1 idle samples.
    for (int i = 0; i < 2; i++) exp_q.push_back(a[18:0]);
    for (int i = 0; i <= DR; i++) exp_q.push_back(IDLE);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < bts[k]; i++) exp_q.push_back(cmds[k][18:0]);
      for (int i = 0; i <= DR; i++) exp_q.push_back(IDLE);
    end
    count_switch_tvalid = 1'b1;
    for (int n = 0; n < exp_q.size(); n++) begin
      tick();
      if (cmd_done) dones++;
      total++; if (ctrl !== exp_q[n]) begin bad++; $display("FAIL b2b_ctrl_cyc%0d: got %h want %h", n, ctrl, exp_q[n]); end
    end
    count_switch_tvalid = 1'b0;
    total++; if (dones !== 5) begin bad++; $display("FAIL b2b_done_count: got %0d want 5", dones); end
    total++; if (busy !== 1'b0 || cmd_tready !== 1'b1) begin bad++; $display("FAIL b2b_end_state: busy %b tready %b want 0 1", busy, cmd_tready); end
  endtask

  task automatic test_illegal();
    logic [35:0] cmds [4];
    cmds[0] = mk(7, 0, 0, 0, 1, 1'b0);
    cmds[1] = mk(1, 9, 0, 0, 1, 1'b0);
    cmds[2] = mk(1, 0, 0, 0, 0, 1'b0);
    cmds[3] = mk(6, 8, 5, 300, 1, 1'b1);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cmd_tvalid = (k < 4);
      if (k < 4) cmd_tdata = cmds[k];
      tick();
      if (k >= 1 && k <= 3) begin
        total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse%0d: got %b want 1", k, err_illegal); end
        total++; if (ctrl !== IDLE) begin bad++; $display("FAIL illegal_ctrl%0d: got %h want %h", k, ctrl, IDLE); end
      end else if (k == 4) begin
        total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL illegal_after_legal: got %b want 0", err_illegal); end
        total++; if (ctrl !== cmds[3][18:0]) begin bad++; $display("FAIL illegal_legal_ctrl: got %h want %h", ctrl, cmds[3][18:0]); end
      end
    end
    cmd_tvalid = 1'b0;
    count_switch_tvalid = 1'b1; tick(); count_switch_tvalid = 1'b0;
    for (int i = 0; i < DR + 1; i++) tick();
  endtask

  task automatic test_backpressure();
    logic [35:0] c;
    do_reset();
    c = mk(4, 5, $urandom_range(0, 7), $urandom_range(0, 511), 4, 1'b0);
    cmd_tvalid = 1'b1; cmd_tdata = c; tick(); cmd_tvalid = 1'b0; tick();
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < 5; g++) begin
        tick();
        total++; if (ctrl !== c[18:0] || beats_left !== 16'(4 - p)) begin bad++; $display("FAIL bp_hold_p%0d_g%0d: ctrl %h beats %0d want %h %0d", p, g, ctrl, beats_left, c[18:0], 4 - p); end
      end
      count_switch_tvalid = 1'b1; tick(); count_switch_tvalid = 1'b0;
      total++; if (beats_left !== 16'(3 - p)) begin bad++; $display("FAIL bp_step%0d: got %0d want %0d", p, beats_left, 3 - p); end
      total++; if (ctrl !== ((p == 3) ? IDLE : c[18:0])) begin bad++; $display("FAIL bp_ctrl%0d: got %h", p, ctrl); end
    end
    for (int i = 0; i < DR + 1; i++) tick();
  endtask

  task automatic test_spurious();
    logic [35:0] c;
    do_reset();
    count_switch_tvalid = 1'b1; tick(); count_switch_tvalid = 1'b0;
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_idle: got %b want 1", err_spurious); end
    total++; if (beats_left !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL spur_idle_state: beats %0d busy %b want 0 0", beats_left, busy); end
    tick();
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_idle_clear: got %b want 0", err_spurious); end
    c = mk(2, 3, 1, 17, 1, 1'b1);
    cmd_tvalid = 1'b1; cmd_tdata = c; tick(); cmd_tvalid = 1'b0; tick();
    count_switch_tvalid = 1'b1; tick();
    total++; if (ctrl !== IDLE || err_spurious !== 1'b0) begin bad++; $display("FAIL spur_final_beat: ctrl %h spur %b", ctrl, err_spurious); end
    tick(); count_switch_tvalid = 1'b0;
    total++; if (err_spurious !== 1'b1 || cmd_done !== 1'b0) begin bad++; $display("FAIL spur_drain: spur %b done %b want 1 0", err_spurious, cmd_done); end
    tick();
    total++; if (cmd_done !== 1'b1 || err_spurious !== 1'b0) begin bad++; $display("FAIL spur_drain_done: done %b spur %b want 1 0", cmd_done, err_spurious); end
    total++; if (busy !== 1'b0 || beats_left !== 16'd0) begin bad++; $display("FAIL spur_end: busy %b beats %0d", busy, beats_left); end
  endtask

  task automatic test_max_beats();
    logic [35:0] c;
    do_reset();
    c = mk(3, 4, 2, 99, 65535, 1'b0);
    cmd_tvalid = 1'b1; cmd_tdata = c; tick(); cmd_tvalid = 1'b0; tick();
    total++; if (beats_left !== 16'hFFFF) begin bad++; $display("FAIL max_beats_load: got %0d want 65535", beats_left); end
    count_switch_tvalid = 1'b1; tick(); count_switch_tvalid = 1'b0;
    total++; if (beats_left !== 16'hFFFE || ctrl !== c[18:0]) begin bad++; $display("FAIL max_beats_step: beats %0d ctrl %h", beats_left, ctrl); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cmd_tvalid = 1'b1; cmd_tdata = mk(5, 2, 0, 0, 7, 1'b1); tick(); cmd_tvalid = 1'b0; tick();
    count_switch_tvalid = 1'b1; tick(); tick(); count_switch_tvalid = 1'b0;
    cmd_tvalid = 1'b1; cmd_tdata = mk(1, 1, 0, 0, 2, 1'b0); tick();
    cmd_tdata = mk(2, 2, 0, 0, 2, 1'b0); tick(); cmd_tvalid = 1'b0;
    total++; if (beats_left !== 16'd5 || busy !== 1'b1) begin bad++; $display("FAIL rmr_pre: beats %0d busy %b want 5 1", beats_left, busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (ctrl !== IDLE || busy !== 1'b0) begin bad++; $display("FAIL rmr_after: ctrl %h busy %b want %h 0", ctrl, busy, IDLE); end
    total++; if (beats_left !== 16'd0 || weight_switch !== 1'b0 || cmd_done !== 1'b0) begin bad++; $display("FAIL rmr_regs: beats %0d w %b done %b", beats_left, weight_switch, cmd_done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (cmd_done !== 1'b0 || ctrl !== IDLE) begin bad++; $display("FAIL rmr_quiet%0d: done %b ctrl %h", i, cmd_done, ctrl); end
    end
  endtask

  task automatic test_random();
    logic [35:0] pend [$];
    logic [35:0] legal_q [$];
    logic [35:0] c, h;
    logic [18:0] prev_ctrl;
    logic        prev_pulse, exp_w, pushed, lg;
    int n_ill_exp = 0, n_ill_seen = 0, n_done = 0, n_legal = 0;
    int rem = 0, since = 1000, cyc = 0;
    do_reset();
    for (int i = 0; i < 40; i++)
      pend.push_back(mk($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 7),
                        $urandom_range(0, 511), $urandom_range(0, 4), 1'($urandom_range(0, 1))));
    exp_w = 1'b0;
    while ((pend.size() > 0 || busy || since <= DR) && cyc < 5000) begin
      cmd_tvalid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      if (cmd_tvalid) cmd_tdata = pend[0];
      count_switch_tvalid = 1'($urandom_range(0, 1));
      pushed = cmd_tvalid && cmd_tready;
      prev_ctrl = ctrl; prev_pulse = count_switch_tvalid;
      tick(); cyc++;
      if (pushed) begin
        c  = pend.pop_front();
        lg = (c[2:0] >= 3'd1) && (c[2:0] <= 3'd6) && (c[6:3] <= 4'd8) && (c[34:19] != 16'd0);
        if (lg) begin legal_q.push_back(c); n_legal++; end
        else n_ill_exp++;
      end
      if (err_illegal) n_ill_seen++;
      if (cmd_done) n_done++;
      total++; if (err_spurious !== (prev_pulse && prev_ctrl == IDLE)) begin bad++; $display("FAIL rnd_spur_c%0d: got %b", cyc, err_spurious); end
      if (prev_ctrl != IDLE) begin
        if (prev_pulse) rem--;
        if (rem == 0) since = 0;
        total++; if (ctrl !== ((rem == 0) ? IDLE : prev_ctrl)) begin bad++; $display("FAIL rnd_ctrl_c%0d: got %h prev %h rem %0d", cyc, ctrl, prev_ctrl, rem); end
        total++; if (beats_left !== 16'(rem)) begin bad++; $display("FAIL rnd_beats_c%0d: got %0d want %0d", cyc, beats_left, rem); end
      end else begin
        if (since < 1000) since++;
        if (ctrl != IDLE) begin
          total++;
          if (legal_q.size() == 0) begin
            bad++; $display("FAIL rnd_unexpected_route_c%0d: got %h want %h", cyc, ctrl, IDLE);
          end else begin
            h = legal_q.pop_front();
            if (ctrl !== h[18:0] || beats_left !== h[34:19]) begin bad++; $display("FAIL rnd_route_c%0d: ctrl %h beats %0d want %h %0d", cyc, ctrl, beats_left, h[18:0], h[34:19]); end
            exp_w = h[35]; rem = int'(h[34:19]);
          end
          total++; if (since < DR + 1) begin bad++; $display("FAIL rnd_gap_c%0d: got %0d want >=%0d", cyc, since, DR + 1); end
        end
      end
      total++; if (weight_switch !== exp_w) begin bad++; $display("FAIL rnd_weight_c%0d: got %b want %b", cyc, weight_switch, exp_w); end
      total++; if (cmd_done !== (since == DR)) begin bad++; $display("FAIL rnd_done_c%0d: got %b want %b", cyc, cmd_done, since == DR); end
    end
    cmd_tvalid = 1'b0; count_switch_tvalid = 1'b0;
    total++; if (cyc >= 5000) begin bad++; $display("FAIL rnd_timeout: got %0d cycles want <5000", cyc); end
    total++; if (n_ill_seen !== n_ill_exp) begin bad++; $display("FAIL rnd_illegal_count: got %0d want %0d", n_ill_seen, n_ill_exp); end
    total++; if (n_done !== n_legal) begin bad++; $display("FAIL rnd_done_count: got %0d want %0d", n_done, n_legal); end
    total++; if (legal_q.size() !== 0) begin bad++; $display("FAIL rnd_leftover: got %0d want 0", legal_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_spurious();
    test_max_beats();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
